// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the accumulator-CPU instruction sequencer.
package cpu_seq_pkg;

    localparam int ST_W = 3;

    // Encodings are visible on the st port, so every value is pinned explicitly.
    typedef enum logic [ST_W-1:0] {
        S_RESET    = 3'd0,
        S_FETCH    = 3'd1,
        S_DECODE   = 3'd2,
        S_EXECUTE  = 3'd3,
        S_MEMWAIT  = 3'd4,
        S_HALTED   = 3'd5,
        S_STEPWAIT = 3'd6,
        S_FAULT    = 3'd7
    } state_t;

endpackage

// File: rtl/seq_timeout_ctr.sv
// Data-memory wait-state counter: clears while idle, counts while enabled,
// and flags the last permitted wait cycle.
module seq_timeout_ctr #(
    parameter int TERMINAL = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int CW = $clog2(TERMINAL + 1);

    logic [CW-1:0] r_cnt;

    // Cycle counter; clear has priority so every wait window starts at zero.
    // NOTE: sequential state uses non-blocking assignments so all registers see
    // the same pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tc = (r_cnt == CW'(TERMINAL - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle sequencer for the 16-bit accumulator CPU: fetch/decode/execute
// phases, memory wait states with timeout, halt/resume, single-step and an
// instruction-retire counter.
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             bra,
    input  logic             hlt,
    input  logic             mem_op,
    input  logic             mem_ready,
    input  logic             step_mode,
    input  logic             step_req,
    input  logic             resume,
    output logic             core_rst,
    output logic             IR_en,
    output logic             CU_en,
    output logic             mem_req,
    output logic             PC_en,
    output logic             force_inc,
    output logic             halted,
    output logic             fault,
    output logic [ST_W-1:0]  st,
    output logic [CNT_W-1:0] retired
);

    state_t           r_state;
    state_t           w_next;
    logic             r_resume;
    logic [CNT_W-1:0] r_retired;
    logic             w_tmo_tc;
    logic             w_in_memwait;
    logic             w_unused_bra;

    // bra only steers the PC mux (BADR during EXECUTE); sequencing ignores it.
    assign w_unused_bra = bra;
    assign w_in_memwait = (r_state == S_MEMWAIT);

    seq_timeout_ctr #(
        .TERMINAL (MEM_TIMEOUT)
    ) u_tmo (
        .clk   (clk),
        .rst   (rst),
        .i_clr (~w_in_memwait),
        .i_en  (w_in_memwait),
        .o_tc  (w_tmo_tc)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_next;
        end
    end

    // Resume flag: set when leaving HALTED, consumed by the following EXECUTE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resume <= 1'b0;
        end else if ((r_state == S_HALTED) && resume) begin
            r_resume <= 1'b1;
        end else if (r_state == S_EXECUTE) begin
            r_resume <= 1'b0;
        end
    end

    // Retire counter: one count per EXECUTE cycle, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retired <= '0;
        end else if (r_state == S_EXECUTE) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    // Next-state and per-phase enables, decoded only from registered state.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_next    = r_state;
        core_rst  = 1'b0;
        IR_en     = 1'b0;
        CU_en     = 1'b0;
        mem_req   = 1'b0;
        PC_en     = 1'b0;
        force_inc = 1'b0;
        halted    = 1'b0;
        fault     = 1'b0;
        case (r_state)
            S_RESET: begin
                core_rst = 1'b1;
                if (run) w_next = S_FETCH;
            end
            S_FETCH: begin
                IR_en  = 1'b1;
                w_next = S_DECODE;
            end
            S_DECODE: begin
                CU_en = 1'b1;
                if (hlt)         w_next = S_HALTED;
                else if (mem_op) w_next = S_MEMWAIT;
                else             w_next = S_EXECUTE;
            end
            S_MEMWAIT: begin
                mem_req = 1'b1;
                if (mem_ready)     w_next = S_EXECUTE;
                else if (w_tmo_tc) w_next = S_FAULT;
            end
            S_EXECUTE: begin
                PC_en     = 1'b1;
                force_inc = r_resume;
                w_next    = step_mode ? S_STEPWAIT : S_FETCH;
            end
            S_HALTED: begin
                halted = 1'b1;
                if (resume) w_next = S_EXECUTE;
            end
            S_STEPWAIT: begin
                if (step_req || !step_mode) w_next = S_FETCH;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                w_next = S_RESET;
            end
        endcase
    end

    assign st      = r_state;
    assign retired = r_retired;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer. Stimulus is described per instruction
// (halt / memory latency / single-step choices); each instruction is expanded
// into the per-cycle phase trace it must produce, and a compare process checks
// every cycle of the DUT against that trace.
module tb_cpu_sequencer;

    localparam int TB_TIMEOUT = 16;
    localparam int TB_CNT_W   = 8;   // narrow counter so wrap-around is reachable quickly
    localparam int CNT_MOD    = 1 << TB_CNT_W;

    // Phase codes as defined for the st port.
    localparam int P_RESET = 0, P_FETCH = 1, P_DECODE = 2, P_EXECUTE = 3;
    localparam int P_MEMWAIT = 4, P_HALTED = 5, P_STEPWAIT = 6, P_FAULT = 7;

    logic clk = 1'b0;
    logic rst, run, bra, hlt, mem_op, mem_ready, step_mode, step_req, resume;
    logic core_rst, IR_en, CU_en, mem_req, PC_en, force_inc, halted, fault;
    logic [2:0]          st;
    logic [TB_CNT_W-1:0] retired;

    cpu_sequencer #(
        .MEM_TIMEOUT (TB_TIMEOUT),
        .CNT_W       (TB_CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .bra       (bra),
        .hlt       (hlt),
        .mem_op    (mem_op),
        .mem_ready (mem_ready),
        .step_mode (step_mode),
        .step_req  (step_req),
        .resume    (resume),
        .core_rst  (core_rst),
        .IR_en     (IR_en),
        .CU_en     (CU_en),
        .mem_req   (mem_req),
        .PC_en     (PC_en),
        .force_inc (force_inc),
        .halted    (halted),
        .fault     (fault),
        .st        (st),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        int phase;
        int ret;
        bit force_exp;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_cycle  = 0;
    int   m_retired = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, n_cycle, act, want);
        end
    endtask

    // Output flags implied by a phase: one enable per phase, force_inc as given.
    function automatic logic [7:0] flags_of(input int p, input bit f);
        return {p == P_RESET, p == P_FETCH, p == P_DECODE, p == P_MEMWAIT,
                p == P_EXECUTE, f, p == P_HALTED, p == P_FAULT};
    endfunction

    // Compare process: one expected record per clock cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            check("st", 32'(st), 32'(cur.phase));
            check("flags", 32'({core_rst, IR_en, CU_en, mem_req, PC_en, force_inc, halted, fault}),
                  32'(flags_of(cur.phase, cur.force_exp)));
            check("retired", 32'(retired), 32'(cur.ret));
        end
        n_cycle++;
    end

    // Randomise every input; callers then override the ones the phase samples.
    task automatic noise();
        run       = 1'($urandom_range(0, 1));
        bra       = 1'($urandom_range(0, 1));
        hlt       = 1'($urandom_range(0, 1));
        mem_op    = 1'($urandom_range(0, 1));
        mem_ready = 1'($urandom_range(0, 1));
        step_mode = 1'($urandom_range(0, 1));
        step_req  = 1'($urandom_range(0, 1));
        resume    = 1'($urandom_range(0, 1));
    endtask

    // Record what this cycle must show, then advance to just after the next edge.
    task automatic cyc(input int p, input bit f);
        exp_t e;
        e.phase     = p;
        e.ret       = m_retired;
        e.force_exp = f;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int idle);
        noise(); rst = 1'b1; m_retired = 0; cyc(P_RESET, 1'b0);
        noise(); cyc(P_RESET, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < idle; k++) begin
            noise(); run = 1'b0; cyc(P_RESET, 1'b0);
        end
        noise(); run = 1'b1; cyc(P_RESET, 1'b0);
    endtask

    task automatic fault_hold(input int n);
        for (int k = 0; k < n; k++) begin
            noise(); cyc(P_FAULT, 1'b0);
        end
    endtask

    // One instruction starting in FETCH. lat = wait cycles before mem_ready;
    // lat >= TB_TIMEOUT never answers. sw_drop leaves STEPWAIT by clearing
    // step_mode instead of pulsing step_req.
    task automatic instr(input bit h, input bit m, input int lat, input int halt_len,
                         input bit step_i, input int sw_len, input bit sw_drop,
                         output bit faulted);
        bit fexp;
        fexp    = 1'b0;
        faulted = 1'b0;
        noise(); cyc(P_FETCH, 1'b0);
        noise(); hlt = h; mem_op = m; cyc(P_DECODE, 1'b0);
        if (h) begin
            for (int k = 0; k < halt_len; k++) begin
                noise(); resume = 1'b0; cyc(P_HALTED, 1'b0);
            end
            noise(); resume = 1'b1; cyc(P_HALTED, 1'b0);
            fexp = 1'b1;
        end else if (m) begin
            for (int k = 0; k < TB_TIMEOUT; k++) begin
                noise(); mem_ready = (k == lat); cyc(P_MEMWAIT, 1'b0);
                if (k == lat) break;
            end
            if (lat >= TB_TIMEOUT) begin
                faulted = 1'b1;
                return;
            end
        end
        noise(); step_mode = step_i; cyc(P_EXECUTE, fexp);
        m_retired = (m_retired + 1) % CNT_MOD;
        if (step_i) begin
            for (int k = 0; k < sw_len; k++) begin
                noise(); step_mode = 1'b1; step_req = 1'b0; cyc(P_STEPWAIT, 1'b0);
            end
            noise();
            step_mode = !sw_drop;
            step_req  = !sw_drop;
            cyc(P_STEPWAIT, 1'b0);
        end
    endtask

    task automatic rand_instr(input bit allow_fault, output bit faulted);
        bit h, m, s, d;
        int lat, hl, sl;
        h   = ($urandom_range(0, 7) == 0);
        m   = ($urandom_range(0, 2) == 0);
        s   = ($urandom_range(0, 3) == 0);
        d   = ($urandom_range(0, 3) == 0);
        hl  = int'($urandom_range(0, 4));
        sl  = int'($urandom_range(0, 3));
        if (allow_fault && ($urandom_range(0, 9) == 0))
            lat = TB_TIMEOUT + int'($urandom_range(0, 2));
        else
            lat = int'($urandom_range(0, 5));
        instr(h, m, lat, hl, s, sl, d, faulted);
    endtask

    initial begin
        bit f;
        rst = 1'b1;
        noise();
        @(posedge clk);
        #1;

        // Reset and idle with run low, then start.
        do_reset(10);
        check("pin_fetch_after_run", 32'(st), 32'd1);

        // Three plain instructions.
        for (int i = 0; i < 3; i++) instr(0, 0, 0, 0, 0, 0, 0, f);
        check("pin_retired_3", 32'(retired), 32'd3);
        check("pin_back_in_fetch", 32'(st), 32'd1);

        // Memory wait of four cycles; answer on the last cycle of the window.
        instr(0, 1, 3, 0, 0, 0, 0, f);
        instr(0, 1, TB_TIMEOUT - 1, 0, 0, 0, 0, f);
        check("pin_retired_5", 32'(retired), 32'd5);

        // Memory never answers -> fault, sticky until reset.
        instr(0, 1, TB_TIMEOUT, 0, 0, 0, 0, f);
        check("fault_reported", 32'(f), 32'd1);
        fault_hold(6);
        check("pin_fault_sticky", 32'({st, fault}), 32'({3'd7, 1'b1}));
        do_reset(2);

        // Halt for twenty cycles, then resume.
        instr(1, 0, 0, 20, 0, 0, 0, f);
        check("pin_retired_after_resume", 32'(retired), 32'd1);

        // Single-step with step_req held, then one exit by dropping step_mode.
        for (int i = 0; i < 3; i++) instr(0, 0, 0, 0, 1, 0, 0, f);
        instr(0, 1, 1, 0, 1, 2, 1, f);

        // Reset in the middle of a memory wait.
        noise(); cyc(P_FETCH, 1'b0);
        noise(); hlt = 1'b0; mem_op = 1'b1; cyc(P_DECODE, 1'b0);
        noise(); mem_ready = 1'b0; cyc(P_MEMWAIT, 1'b0);
        do_reset(1);

        // Long random run without faults, crossing the counter wrap.
        for (int i = 0; i < CNT_MOD - 1; i++) rand_instr(0, f);
        check("pin_retired_max", 32'(retired), 32'(CNT_MOD - 1));
        instr(0, 0, 0, 0, 0, 0, 0, f);
        check("pin_retired_wrap", 32'(retired), 32'd0);

        // Random run with occasional timeouts.
        for (int i = 0; i < 150; i++) begin
            rand_instr(1, f);
            if (f) begin
                fault_hold(int'($urandom_range(1, 4)));
                do_reset(int'($urandom_range(0, 3)));
            end
        end

        #10;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
